// File: rtl/cla_limb_sequencer.sv
// Multi-limb adder sequencer: streams LIMBS 8-bit operand pairs (LSB limb
// first) through an external 8-bit carry-lookahead adder, chaining the carry
// between limbs in a register and presenting one registered sum limb per
// accepted pair on a valid/ready output stream.
module cla_limb_sequencer #(
    parameter int LIMBS = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ena,
    input  logic       i_start,
    input  logic       i_cin,
    input  logic       i_in_valid,
    input  logic [7:0] i_in_a,
    input  logic [7:0] i_in_b,
    output logic       o_in_ready,
    output logic       o_out_valid,
    output logic [7:0] o_out_sum,
    output logic       o_out_last,
    input  logic       i_out_ready,
    output logic       o_cout,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_add_a,
    output logic [7:0] o_add_b,
    output logic       o_add_cin,
    input  logic [7:0] i_add_sum,
    input  logic       i_add_cout
);

    localparam int CW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_limb_cnt;
    logic            r_carry;
    logic            r_out_valid;
    logic            r_out_last;
    logic [7:0]      r_out_sum;
    logic            r_cout;
    logic            r_done;

    logic            w_accept;
    logic            w_last_limb;
    logic            w_drain;

    // The adder sits outside; operands pass straight through and the chained
    // carry comes from the carry register, so the sum is usable this cycle.
    assign o_add_a   = i_in_a;
    assign o_add_b   = i_in_b;
    assign o_add_cin = r_carry;

    // A new pair may enter only while the output slot is empty or draining.
    assign o_in_ready  = i_ena && (r_state == S_RUN) && (!r_out_valid || i_out_ready);
    assign w_accept    = o_in_ready && i_in_valid;
    assign w_last_limb = (r_limb_cnt == CW'(LIMBS - 1));
    assign w_drain     = i_ena && r_out_valid && i_out_ready;

    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_out_sum;
    assign o_out_last  = r_out_last;
    assign o_cout      = r_cout;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; a disabled cycle freezes every transition.
    always_comb begin
        w_state_nxt = r_state;
        if (i_ena) begin
            case (r_state)
                S_IDLE:  if (i_start)                 w_state_nxt = S_RUN;
                S_RUN:   if (w_accept && w_last_limb) w_state_nxt = S_DONE;
                S_DONE:  if (w_drain)                 w_state_nxt = S_IDLE;
                default:                              w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: carry chain, limb counter and the registered output slot.
    // start outside IDLE falls through untouched, so it cannot disturb a run.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_limb_cnt  <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sum   <= 8'h00;
            r_cout      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // done is a pulse: it never survives more than one edge.
            r_done <= 1'b0;
            if (i_ena) begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_carry    <= i_cin;
                            r_limb_cnt <= '0;
                            r_cout     <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (w_accept) begin
                            r_out_sum   <= i_add_sum;
                            r_out_valid <= 1'b1;
                            r_carry     <= i_add_cout;
                            if (w_last_limb) begin
                                // Counter parks at LIMBS-1 rather than wrapping.
                                r_out_last <= 1'b1;
                                r_cout     <= i_add_cout;
                            end else begin
                                r_out_last <= 1'b0;
                                r_limb_cnt <= r_limb_cnt + 1'b1;
                            end
                        end else if (w_drain) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        if (w_drain) begin
                            r_done      <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cla_limb_sequencer.sv
// Bench for cla_limb_sequencer (LIMBS=4): models the external adder, drives
// directed and randomized multi-limb adds, and checks the output stream
// against a full-width arithmetic reference of A+B+cin.
module tb_cla_limb_sequencer;

    localparam int LIMBS = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       cin;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_ready;
    logic       cout;
    logic       busy;
    logic       done;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       add_cout;
    logic [8:0] add_res;

    int total = 0;
    int bad   = 0;

    cla_limb_sequencer #(.LIMBS(LIMBS)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_ena      (ena),
        .i_start    (start),
        .i_cin      (cin),
        .i_in_valid (in_valid),
        .i_in_a     (in_a),
        .i_in_b     (in_b),
        .o_in_ready (in_ready),
        .o_out_valid(out_valid),
        .o_out_sum  (out_sum),
        .o_out_last (out_last),
        .i_out_ready(out_ready),
        .o_cout     (cout),
        .o_busy     (busy),
        .o_done     (done),
        .o_add_a    (add_a),
        .o_add_b    (add_b),
        .o_add_cin  (add_cin),
        .i_add_sum  (add_sum),
        .i_add_cout (add_cout)
    );

    // External 8-bit adder behaviour.
    assign add_res  = 9'(add_a) + 9'(add_b) + 9'(add_cin);
    assign add_sum  = add_res[7:0];
    assign add_cout = add_res[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_cout"},      32'(cout),      32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_out_sum"},   32'(out_sum),   32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    endtask

    // mode: 0 plain, 1 three-cycle output stall after first sum,
    // 2 start pulse mid-run, 3 two ena-low cycles mid-run,
    // 4 random in_valid/out_ready, 5 reset after two limbs accepted.
    task automatic run_add(input logic [31:0] a, input logic [31:0] b,
                           input logic c, input int mode);
        logic [32:0] ref_sum;
        int fed, got, stall_left, ena_left;
        bit stalled_once, ena_once, start_once, finished, last_seen, p_hold;
        logic [7:0] p_sum;
        logic p_valid, p_last;
        ref_sum = 33'(a) + 33'(b) + 33'(c);
        fed = 0; got = 0; stall_left = 0; ena_left = 0;
        stalled_once = 0; ena_once = 0; start_once = 0;
        finished = 0; last_seen = 0; p_hold = 0;
        p_sum = 8'h00; p_valid = 1'b0; p_last = 1'b0;

        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        ena = 1'b1; start = 1'b1; cin = c; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run_busy", 32'(busy), 32'd1);

        for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (p_hold) begin
                chk("hold_sum",   32'(out_sum),   32'(p_sum));
                chk("hold_valid", 32'(out_valid), 32'(p_valid));
                chk("hold_last",  32'(out_last),  32'(p_last));
            end
            if (last_seen) begin
                chk("done_pulse", 32'(done),      32'd1);
                chk("done_busy",  32'(busy),      32'd0);
                chk("done_valid", 32'(out_valid), 32'd0);
                chk("done_cout",  32'(cout),      32'(ref_sum[32]));
                finished = 1;
            end else begin
                chk("no_done", 32'(done), 32'd0);
            end
            if (!finished && mode == 5 && fed == 2) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk_idle_zero("abort");
                rst_n = 1'b1;
                finished = 1;
            end else if (!finished) begin
                if (mode == 3 && fed == 2 && !ena_once) begin
                    ena_left = 2; ena_once = 1;
                end
                ena = (ena_left == 0);
                if (ena_left > 0) ena_left--;
                if (mode == 1 && out_valid && !stalled_once) begin
                    stall_left = 3; stalled_once = 1;
                end
                if (mode == 4) out_ready = ($urandom_range(0, 3) != 0);
                else           out_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                in_valid = (fed < LIMBS) && (mode != 4 || $urandom_range(0, 3) != 0);
                in_a = (fed < LIMBS) ? a[fed*8 +: 8] : 8'h00;
                in_b = (fed < LIMBS) ? b[fed*8 +: 8] : 8'h00;
                if (mode == 2 && fed == 2 && !start_once) begin
                    start = 1'b1; cin = ~c; start_once = 1;
                end else begin
                    start = 1'b0;
                end
                #1;
                chk("in_ready", 32'(in_ready),
                    32'(ena && fed < LIMBS && (!out_valid || out_ready)));
                if (ena && out_valid && out_ready) begin
                    if (got < LIMBS) begin
                        chk("sum_limb", 32'(out_sum), 32'(ref_sum[got*8 +: 8]));
                        chk("out_last", 32'(out_last), 32'(got == LIMBS - 1));
                        if (got == LIMBS - 1) begin
                            chk("cout", 32'(cout), 32'(ref_sum[32]));
                            last_seen = 1;
                        end
                    end else begin
                        chk("extra_limb", 32'(got), 32'(LIMBS - 1));
                    end
                    got++;
                end
                if (in_ready && in_valid) fed++;
                p_hold  = !ena || (out_valid && !out_ready);
                p_sum   = out_sum;
                p_valid = out_valid;
                p_last  = out_last;
            end
        end
        if (!finished) chk("timeout", 32'd0, 32'd1);
        start = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; cin = 1'b0;
        in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;

        run_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_add(32'h1234_5678, 32'h1111_1111, 1'b1, 0);
        run_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1);
        run_add($urandom, $urandom, 1'($urandom), 1);
        run_add(32'h89AB_CDEF, 32'h7654_3210, 1'b0, 2);
        run_add($urandom, $urandom, 1'b1, 2);
        run_add(32'hFF00_FF00, 32'h00FF_01FF, 1'b0, 3);
        run_add($urandom, $urandom, 1'($urandom), 3);
        run_add(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 5);
        run_add(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
        for (int i = 0; i < 12; i++)
            run_add($urandom, $urandom, 1'($urandom), (i % 3 == 0) ? 0 : 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
